alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//   Decode/execute pipeline register directly upstream of the ALU. Accepts decoded ops with a
//   valid/ready handshake, resolves operand B (rs2 vs imm) and writeback forwarding, registers the
//   operands, and drives the ALU's one-hot selects. A 2-entry skid buffer keeps in_ready registered.
// PARAMETERS
//   WIDTH   32  datapath width of operands, immediate and forward data
//   RBITS   5   register index width
// PORTS
//   clk           in   1      clock, all state on rising edge
//   rst_n         in   1      asynchronous active-low reset
//   flush         in   1      sync kill of all held entries (branch redirect)
//   in_valid      in   1      upstream op valid
//   in_ready      out  1      stage can accept op this cycle
//   in_op         in   3      0 ADD,1 SUB,2 NOP,3 PASS1,4 PASS2,5-7 illegal
//   in_rs1        in   RBITS  source 1 index
//   in_rs2        in   RBITS  source 2 index
//   in_rs1_data   in   WIDTH  register file read 1
//   in_rs2_data   in   WIDTH  register file read 2
//   in_imm        in   WIDTH  sign-extended immediate
//   in_use_imm    in   1      1: operand B = in_imm
//   in_rd         in   RBITS  destination index
//   fwd_valid     in   1      writeback result valid this cycle
//   fwd_rd        in   RBITS  writeback destination
//   fwd_data      in   WIDTH  writeback value
//   out_valid     out  1      ALU inputs hold a live op
//   out_ready     in   1      downstream consumes op this cycle
//   operand_a     out  WIDTH  ALU operand A
//   operand_b     out  WIDTH  ALU operand B
//   alu_sel_add / alu_sel_sub / alu_sel_nop / alu_sel_pass1 / alu_sel_pass2  out 1 each, one-hot
//   out_rd        out  RBITS  destination of op at ALU
//   out_illegal   out  1      op code was 5-7 (converted to NOP)
// BEHAVIOUR
// - Reset (async, rst_n=0): both entries invalid; out_valid=0, in_ready=1, operands/out_rd=0,
//   alu_sel_nop=1 and other selects 0, out_illegal=0.
// - Accept when in_valid&&in_ready; transfer when out_valid&&out_ready. Latency in->out 1 cycle.
// - Capture: a = (fwd_valid && fwd_rd!=0 && fwd_rd==in_rs1) ? fwd_data : in_rs1_data;
//   b = in_use_imm ? in_imm : (same forward rule on in_rs2 else in_rs2_data). rd/index 0 never fwd.
// - Forward is sampled only at capture; held entries are not re-forwarded.
// - Decode: op 0-4 -> exactly one select set; op 5-7 -> alu_sel_nop=1, out_illegal=1.
// - Selects are always exactly one-hot; when out_valid=0 they are NOP-only, operands hold last value.
// - Entries: MAIN (drives outputs), SKID. States by occupancy: EMPTY, ONE(main), FULL(main+skid).
//   EMPTY: accept -> ONE.  ONE: accept&&!transfer -> FULL (new op to SKID); accept&&transfer ->
//   ONE (new op to MAIN); transfer only -> EMPTY.  FULL: transfer -> ONE (SKID moves to MAIN);
//   no accept possible.
// - in_ready = !FULL, driven from a flop (no comb path from out_ready).
// - Order preserved: SKID op always emerges after MAIN op.
// - flush=1: next state EMPTY regardless of in_valid/out_ready; same-cycle accept discarded;
//   selects return to NOP-only, out_illegal=0. Flush wins over all other events.
// - Reset mid-operation: immediate return to reset values, no op survives.
// - No arithmetic in this block; all data widths pass through unmodified (no truncation).
// TESTING
// - ADD, rs1=1 data 7, rs2=2 data 5, out_ready=1 -> next cycle out_valid=1, a=7, b=5, sel_add=1.
// - Two ops, out_ready=0 -> state FULL, in_ready=0 after 2nd accept; raise out_ready -> ops exit
//   in order on consecutive cycles, in_ready=1 one cycle after first transfer.
// - in_use_imm=1, imm=32'hFFFF_FFF0, op SUB -> b=32'hFFFF_FFF0, sel_sub=1, rs2_data ignored.
// - fwd_valid=1, fwd_rd=3, fwd_data=32'hAA; op rs1=3 rs1_data=0 -> a=32'hAA; repeat with
//   rs1=0, fwd_rd=0 -> a=rs1_data.
// - op=6 -> sel_nop=1, out_illegal=1, all other selects 0.
// - FULL then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, sel_nop=1; drop rst_n
//   mid-stream -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/execute pipeline register feeding the ALU.
// It takes decoded ops over a valid/ready handshake. At capture it picks operand B
// (rs2 or immediate) and applies writeback forwarding. It registers the operands and
// one-hot ALU selects. A 2-entry (MAIN + SKID) buffer lets in_ready come from a flop.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   flush                    sync kill of all held entries
//   in_valid/in_ready        upstream handshake; in_op, in_rs1/2, in_rs1/2_data,
//                            in_imm, in_use_imm, in_rd carry the decoded op
//   fwd_valid/fwd_rd/fwd_data  writeback forward bus
//   out_valid/out_ready      downstream handshake
//   operand_a/operand_b, alu_sel_*, out_rd, out_illegal  registered ALU inputs
module alu_issue_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RBITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [RBITS-1:0] in_rs1,
  input  logic [RBITS-1:0] in_rs2,
  input  logic [WIDTH-1:0] in_rs1_data,
  input  logic [WIDTH-1:0] in_rs2_data,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [RBITS-1:0] in_rd,
  input  logic             fwd_valid,
  input  logic [RBITS-1:0] fwd_rd,
  input  logic [WIDTH-1:0] fwd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic             alu_sel_add,
  output logic             alu_sel_sub,
  output logic             alu_sel_nop,
  output logic             alu_sel_pass1,
  output logic             alu_sel_pass2,
  output logic [RBITS-1:0] out_rd,
  output logic             out_illegal
);

  localparam int unsigned SELW = 5;
  // Select vector bit order: {pass2, pass1, nop, sub, add}
  localparam logic [SELW-1:0] SEL_ADD   = 5'b00001;
  localparam logic [SELW-1:0] SEL_SUB   = 5'b00010;
  localparam logic [SELW-1:0] SEL_NOP   = 5'b00100;
  localparam logic [SELW-1:0] SEL_PASS1 = 5'b01000;
  localparam logic [SELW-1:0] SEL_PASS2 = 5'b10000;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SELW-1:0]  sel;
    logic             illegal;
    logic [RBITS-1:0] rd;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t cap_c;
  logic   out_valid_q;
  logic   in_ready_q;
  logic   accept_c;
  logic   transfer_c;

  assign accept_c   = in_valid && in_ready_q;
  assign transfer_c = out_valid_q && out_ready;

  // Build the entry that would be captured this cycle; register 0 is never forwarded.
  always_comb begin
    cap_c    = '0;
    cap_c.rd = in_rd;
    cap_c.a  = (fwd_valid && (fwd_rd != '0) && (fwd_rd == in_rs1)) ? fwd_data : in_rs1_data;
    if (in_use_imm)
      cap_c.b = in_imm;
    else if (fwd_valid && (fwd_rd != '0) && (fwd_rd == in_rs2))
      cap_c.b = fwd_data;
    else
      cap_c.b = in_rs2_data;
    cap_c.sel     = SEL_NOP;
    cap_c.illegal = 1'b0;
    case (in_op)
      3'd0:    cap_c.sel = SEL_ADD;
      3'd1:    cap_c.sel = SEL_SUB;
      3'd2:    cap_c.sel = SEL_NOP;
      3'd3:    cap_c.sel = SEL_PASS1;
      3'd4:    cap_c.sel = SEL_PASS2;
      default: cap_c.illegal = 1'b1;
    endcase
  end

  // Occupancy FSM; MAIN drives the outputs directly, and going empty forces NOP-only selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= EMPTY;
      out_valid_q    <= 1'b0;
      in_ready_q     <= 1'b1;
      main_q.a       <= '0;
      main_q.b       <= '0;
      main_q.sel     <= SEL_NOP;
      main_q.illegal <= 1'b0;
      main_q.rd      <= '0;
      skid_q         <= '0;
    end else if (flush) begin
      state          <= EMPTY;
      out_valid_q    <= 1'b0;
      in_ready_q     <= 1'b1;
      main_q.sel     <= SEL_NOP;
      main_q.illegal <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept_c) begin
            main_q      <= cap_c;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept_c && !transfer_c) begin
            skid_q     <= cap_c;
            in_ready_q <= 1'b0;
            state      <= FULL;
          end else if (accept_c && transfer_c) begin
            main_q <= cap_c;
          end else if (transfer_c) begin
            out_valid_q    <= 1'b0;
            main_q.sel     <= SEL_NOP;
            main_q.illegal <= 1'b0;
            state          <= EMPTY;
          end
        end
        FULL: begin
          if (transfer_c) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state          <= EMPTY;
          out_valid_q    <= 1'b0;
          in_ready_q     <= 1'b1;
          main_q.sel     <= SEL_NOP;
          main_q.illegal <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign operand_a     = main_q.a;
  assign operand_b     = main_q.b;
  assign out_rd        = main_q.rd;
  assign out_illegal   = main_q.illegal;
  assign alu_sel_add   = main_q.sel[0];
  assign alu_sel_sub   = main_q.sel[1];
  assign alu_sel_nop   = main_q.sel[2];
  assign alu_sel_pass1 = main_q.sel[3];
  assign alu_sel_pass2 = main_q.sel[4];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage. It runs directed vectors, hand-written skid/flush/reset
// sequences, and random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_a, operand_b;
  logic        alu_sel_add, alu_sel_sub, alu_sel_nop, alu_sel_pass1, alu_sel_pass2;
  logic [4:0]  out_rd;
  logic        out_illegal;

  alu_issue_stage #(.WIDTH(32), .RBITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand_a(operand_a), .operand_b(operand_b),
    .alu_sel_add(alu_sel_add), .alu_sel_sub(alu_sel_sub), .alu_sel_nop(alu_sel_nop),
    .alu_sel_pass1(alu_sel_pass1), .alu_sel_pass2(alu_sel_pass2),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1d, rs2d, imm;
    logic        use_imm;
    logic        fv;
    logic [4:0]  frd;
    logic [31:0] fd;
    logic [31:0] ea, eb;
    logic [4:0]  esel;   // {pass2, pass1, nop, sub, add}
    logic        eill;
  } vec_t;

  typedef struct {
    logic [31:0] a, b;
    logic [4:0]  sel;
    logic        ill;
    logic [4:0]  rd;
  } exp_t;

  vec_t vecs[8];
  exp_t q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [4:0] sel_vec();
    return {alu_sel_pass2, alu_sel_pass1, alu_sel_nop, alu_sel_sub, alu_sel_add};
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_op = 3'd2; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_use_imm = 0;
    fwd_valid = 0; fwd_rd = 0; fwd_data = 0; flush = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    in_valid = 1; in_op = v.op; in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
    in_rs1_data = v.rs1d; in_rs2_data = v.rs2d; in_imm = v.imm; in_use_imm = v.use_imm;
    fwd_valid = v.fv; fwd_rd = v.frd; fwd_data = v.fd;
  endtask

  task automatic drive_simple(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd);
    in_valid = 1; in_op = op; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = rd;
    in_rs1_data = a; in_rs2_data = b; in_use_imm = 0; fwd_valid = 0;
  endtask

  // Reference: selects per op code, ops 5-7 collapse to NOP flagged illegal.
  function automatic exp_t model_capture(input logic [2:0] op, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] d2,
      input logic [31:0] imm, input logic ui, input logic [4:0] rd,
      input logic fv, input logic [4:0] frd, input logic [31:0] fd);
    exp_t e;
    bit hit1, hit2;
    hit1 = fv && frd != 0 && frd == rs1;
    hit2 = fv && frd != 0 && frd == rs2;
    e.a = hit1 ? fd : d1;
    e.b = ui ? imm : (hit2 ? fd : d2);
    e.rd = rd;
    e.ill = (op > 3'd4);
    e.sel = (op > 3'd4) ? 5'b00100 : 5'(1 << op);
    return e;
  endfunction

  initial begin
    exp_t e;
    logic [31:0] last_a, last_b;
    int sz;
    bit acc, xfer;

    vecs[0] = '{3'd0, 5'd1, 5'd2, 5'd9,  32'd7,  32'd5,    32'd0,          1'b0, 1'b0, 5'd0, 32'd0,
                32'd7,  32'd5,          5'b00001, 1'b0};
    vecs[1] = '{3'd1, 5'd1, 5'd2, 5'd10, 32'd3,  32'h1234, 32'hFFFF_FFF0,  1'b1, 1'b0, 5'd0, 32'd0,
                32'd3,  32'hFFFF_FFF0,  5'b00010, 1'b0};
    vecs[2] = '{3'd2, 5'd3, 5'd4, 5'd11, 32'd0,  32'd8,    32'd0,          1'b0, 1'b1, 5'd3, 32'hAA,
                32'hAA, 32'd8,          5'b00100, 1'b0};
    vecs[3] = '{3'd3, 5'd0, 5'd4, 5'd12, 32'h55, 32'd9,    32'd0,          1'b0, 1'b1, 5'd0, 32'hAA,
                32'h55, 32'd9,          5'b01000, 1'b0};
    vecs[4] = '{3'd6, 5'd1, 5'd2, 5'd13, 32'd1,  32'd2,    32'd0,          1'b0, 1'b0, 5'd0, 32'd0,
                32'd1,  32'd2,          5'b00100, 1'b1};
    vecs[5] = '{3'd4, 5'd5, 5'd4, 5'd14, 32'd6,  32'd0,    32'd0,          1'b0, 1'b1, 5'd4, 32'hDEAD_BEEF,
                32'd6,  32'hDEAD_BEEF,  5'b10000, 1'b0};
    vecs[6] = '{3'd5, 5'd1, 5'd4, 5'd15, 32'd2,  32'd3,    32'h8000_0001,  1'b1, 1'b1, 5'd4, 32'h77,
                32'd2,  32'h8000_0001,  5'b00100, 1'b1};
    vecs[7] = '{3'd7, 5'd6, 5'd7, 5'd31, 32'hFFFF_FFFF, 32'd4, 32'd0,      1'b0, 1'b0, 5'd6, 32'h99,
                32'hFFFF_FFFF, 32'd4,   5'b00100, 1'b1};

    idle_inputs();
    out_ready = 0;
    rst_n = 0;
    #12;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset sel", 64'(sel_vec()), 64'b00100);
    check("reset operands", {operand_a, operand_b}, 64'd0);
    check("reset illegal/rd", {58'd0, out_illegal, out_rd}, 64'd0);
    @(negedge clk); rst_n = 1;

    // Directed vectors: accept, see on outputs one cycle later, then drain.
    foreach (vecs[i]) begin
      @(negedge clk); drive_vec(vecs[i]); out_ready = 1;
      @(posedge clk); #1;
      check($sformatf("vec%0d valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d a", i), 64'(operand_a), 64'(vecs[i].ea));
      check($sformatf("vec%0d b", i), 64'(operand_b), 64'(vecs[i].eb));
      check($sformatf("vec%0d sel", i), 64'(sel_vec()), 64'(vecs[i].esel));
      check($sformatf("vec%0d illegal", i), 64'(out_illegal), 64'(vecs[i].eill));
      check($sformatf("vec%0d rd", i), 64'(out_rd), 64'(vecs[i].rd));
      @(negedge clk); idle_inputs();
      @(posedge clk); #1;
      check($sformatf("vec%0d drained", i), 64'(out_valid), 64'd0);
      check($sformatf("vec%0d idle sel", i), 64'(sel_vec()), 64'b00100);
    end

    // Skid fill with a stalled consumer, then drain in order.
    @(negedge clk); out_ready = 0; drive_simple(3'd0, 32'h111, 32'h222, 5'd1);
    @(posedge clk); #1;
    check("fill1 in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); drive_simple(3'd1, 32'h333, 32'h444, 5'd2);
    @(posedge clk); #1;
    check("full in_ready", 64'(in_ready), 64'd0);
    check("full head a", 64'(operand_a), 64'h111);
    @(negedge clk); idle_inputs(); out_ready = 1;
    @(posedge clk); #1;
    check("drain1 a", 64'(operand_a), 64'h333);
    check("drain1 sel", 64'(sel_vec()), 64'b00010);
    check("drain1 rd", 64'(out_rd), 64'd2);
    check("drain1 in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("drain2 valid", 64'(out_valid), 64'd0);

    // Flush from FULL with a simultaneous offer.
    @(negedge clk); out_ready = 0; drive_simple(3'd3, 32'h5, 32'h6, 5'd3);
    @(negedge clk); drive_simple(3'd6, 32'h7, 32'h8, 5'd4);
    @(negedge clk); drive_simple(3'd0, 32'h9, 32'hA, 5'd5); flush = 1;
    @(posedge clk); #1;
    check("flush valid", 64'(out_valid), 64'd0);
    check("flush in_ready", 64'(in_ready), 64'd1);
    check("flush sel", 64'(sel_vec()), 64'b00100);
    check("flush illegal", 64'(out_illegal), 64'd0);
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    check("post-flush still empty", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream with an illegal op held.
    @(negedge clk); drive_simple(3'd6, 32'hAB, 32'hCD, 5'd7);
    @(negedge clk); drive_simple(3'd4, 32'hEF, 32'h12, 5'd8);
    @(posedge clk); #2; rst_n = 0; #1;
    check("async rst valid", 64'(out_valid), 64'd0);
    check("async rst in_ready", 64'(in_ready), 64'd1);
    check("async rst sel", 64'(sel_vec()), 64'b00100);
    check("async rst data", {operand_a, operand_b}, 64'd0);
    check("async rst illegal/rd", {58'd0, out_illegal, out_rd}, 64'd0);
    @(negedge clk); idle_inputs(); rst_n = 1;

    // Random traffic against the queue model.
    last_a = 0; last_b = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_op       = 3'($urandom_range(0, 7));
      in_rs1      = 5'($urandom_range(0, 3));
      in_rs2      = 5'($urandom_range(0, 3));
      in_rd       = 5'($urandom);
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      in_imm      = $urandom;
      in_use_imm  = 1'($urandom);
      fwd_valid   = 1'($urandom);
      fwd_rd      = 5'($urandom_range(0, 3));
      fwd_data    = $urandom;
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      e = model_capture(in_op, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm,
                        in_use_imm, in_rd, fwd_valid, fwd_rd, fwd_data);
      sz   = q.size();
      acc  = in_valid && (sz < 2);
      xfer = (sz > 0) && out_ready;
      @(posedge clk); #1;
      if (flush) q.delete();
      else begin
        if (xfer) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      check("rnd in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("rnd out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        check("rnd a", 64'(operand_a), 64'(q[0].a));
        check("rnd b", 64'(operand_b), 64'(q[0].b));
        check("rnd sel", 64'(sel_vec()), 64'(q[0].sel));
        check("rnd illegal", 64'(out_illegal), 64'(q[0].ill));
        check("rnd rd", 64'(out_rd), 64'(q[0].rd));
        last_a = q[0].a; last_b = q[0].b;
      end else begin
        check("rnd idle sel", 64'(sel_vec()), 64'b00100);
        check("rnd hold operands", {operand_a, operand_b}, {last_a, last_b});
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
